// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier between two requesters.
// Optional grant counters (gnt_cnt0/gnt_cnt1) are built when ARB_STATS_EN is defined.
module booth_mul_arbiter #(
  parameter int unsigned N   = 16,
  parameter int unsigned LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid0,
  input  logic [N-1:0]         in_a0,
  input  logic [N-1:0]         in_b0,
  output logic                 in_ready0,
  input  logic                 in_valid1,
  input  logic [N-1:0]         in_a1,
  input  logic [N-1:0]         in_b1,
  output logic                 in_ready1,
  output logic [N-1:0]         mul_a,
  output logic [N-1:0]         mul_b,
  input  logic [2*(N+1)-1:0]   mul_m,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [2*(N+1)-1:0]   rsp_m,
  input  logic                 rsp_ready
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]          gnt_cnt0,
  output logic [15:0]          gnt_cnt1
`endif
);

  localparam int unsigned MW   = 2 * (N + 1);
  localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [N-1:0]    mul_a_q, mul_b_q;
  logic [MW-1:0]   rsp_m_q;
  logic            rsp_valid_q, rsp_id_q;
  logic            id_q, last_id_q;
  logic [CntW-1:0] cnt_q;

  logic gnt0, gnt1, accept, win_id;

  // A tie goes to whichever requester did not win last.
  assign gnt0   = in_valid0 & (~in_valid1 | last_id_q);
  assign gnt1   = in_valid1 & (~in_valid0 | ~last_id_q);

  assign in_ready0 = ~rst & (state_q == StIdle) & gnt0;
  assign in_ready1 = ~rst & (state_q == StIdle) & gnt1;
  assign accept    = in_ready0 | in_ready1;
  assign win_id    = in_ready1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_m_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            mul_a_q   <= win_id ? in_a1 : in_a0;
            mul_b_q   <= win_id ? in_b1 : in_b0;
            id_q      <= win_id;
            last_id_q <= win_id;
            cnt_q     <= CntW'(LAT - 1);
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            rsp_m_q     <= mul_m;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_m     = rsp_m_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;

`ifdef ARB_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      if (in_ready0 && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
      if (in_ready1 && gnt_cnt1_q != 16'hFFFF) gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter: a LAT=1 instance for arbitration and
// backpressure, and a LAT=4 instance for settle timing.
module tb_booth_mul_arbiter;

  localparam int unsigned N  = 16;
  localparam int unsigned MW = 2 * (N + 1);

  typedef struct packed {
    logic          id;
    logic [MW-1:0] m;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  int n_cmp = 0;
  int n_err = 0;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // LAT=1 instance
  logic          in_valid0, in_valid1, in_ready0, in_ready1;
  logic [N-1:0]  in_a0, in_b0, in_a1, in_b1, mul_a, mul_b;
  logic [MW-1:0] mul_m, rsp_m;
  logic          rsp_valid, rsp_id, rsp_ready;

  // LAT=4 instance
  logic          v4_0, v4_1, r4_0, r4_1;
  logic [N-1:0]  a4_0, b4_0, a4_1, b4_1, mul_a4, mul_b4;
  logic [MW-1:0] mul_m4, rsp_m4;
  logic          rsp_valid4, rsp_id4, rsp_ready4;

`ifdef ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1, gnt4_0, gnt4_1;
`endif

  // Shared multiplier models (unsigned product of the registered operands).
  assign mul_m  = MW'(mul_a) * MW'(mul_b);
  assign mul_m4 = MW'(mul_a4) * MW'(mul_b4);

  booth_mul_arbiter #(.N(N), .LAT(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid0 (in_valid0),
    .in_a0     (in_a0),
    .in_b0     (in_b0),
    .in_ready0 (in_ready0),
    .in_valid1 (in_valid1),
    .in_a1     (in_a1),
    .in_b1     (in_b1),
    .in_ready1 (in_ready1),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_m     (mul_m),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_m     (rsp_m),
    .rsp_ready (rsp_ready)
`ifdef ARB_STATS_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
`endif
  );

  booth_mul_arbiter #(.N(N), .LAT(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid0 (v4_0),
    .in_a0     (a4_0),
    .in_b0     (b4_0),
    .in_ready0 (r4_0),
    .in_valid1 (v4_1),
    .in_a1     (a4_1),
    .in_b1     (b4_1),
    .in_ready1 (r4_1),
    .mul_a     (mul_a4),
    .mul_b     (mul_b4),
    .mul_m     (mul_m4),
    .rsp_valid (rsp_valid4),
    .rsp_id    (rsp_id4),
    .rsp_m     (rsp_m4),
    .rsp_ready (rsp_ready4)
`ifdef ARB_STATS_EN
    ,
    .gnt_cnt0  (gnt4_0),
    .gnt_cnt1  (gnt4_1)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitors: pop an expectation on every response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got id=%0d m=%0h expected no response", rsp_id, rsp_m);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_m", 64'(rsp_m), 64'(e.m));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid4 && rsp_ready4) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp4_unexpected: got id=%0d m=%0h expected no response", rsp_id4, rsp_m4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("rsp4_id", 64'(rsp_id4), 64'(e.id));
        chk("rsp4_m", 64'(rsp_m4), 64'(e.m));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid0 = 1'b1; in_a0 = '0; in_b0 = '0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0;
    rsp_ready = 1'b0;
    v4_0 = 1'b0; a4_0 = '0; b4_0 = '0;
    v4_1 = 1'b0; a4_1 = '0; b4_1 = '0;
    rsp_ready4 = 1'b1;

    // Reset state, ready gated while in reset
    at_neg();
    chk("reset_in_ready0", 64'(in_ready0), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_mul_a", 64'(mul_a), 64'd0);
    chk("reset_rsp_m", 64'(rsp_m), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    tick();
    tick();
    in_valid0 = 1'b0;
    rst = 1'b0;
    tick();

    // Round robin with both requesters valid: accepts every 3 cycles, 0,1,0,1
    in_valid0 = 1'b1; in_a0 = 16'h0100; in_b0 = 16'h0010;
    in_valid1 = 1'b1; in_a1 = 16'd2;    in_b1 = 16'd7;
    rsp_ready = 1'b1;
    q1.push_back('{id: 1'b0, m: MW'(34'h1000)});
    q1.push_back('{id: 1'b1, m: MW'(34'd14)});
    q1.push_back('{id: 1'b0, m: MW'(34'h1000)});
    q1.push_back('{id: 1'b1, m: MW'(34'd14)});
    for (int k = 0; k < 12; k++) begin
      at_neg();
      chk("rr_ready0", 64'(in_ready0), 64'(k % 6 == 0));
      chk("rr_ready1", 64'(in_ready1), 64'(k % 6 == 3));
      tick();
    end
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;

    // Single request 3*5
    in_valid0 = 1'b1; in_a0 = 16'd3; in_b0 = 16'd5;
    q1.push_back('{id: 1'b0, m: MW'(34'd15)});
    at_neg();
    chk("single_ready0", 64'(in_ready0), 64'd1);
    tick();
    in_valid0 = 1'b0;
    at_neg();
    chk("single_mul_a", 64'(mul_a), 64'd3);
    chk("single_mul_b", 64'(mul_b), 64'd5);
    chk("single_busy_valid", 64'(rsp_valid), 64'd0);
    tick();
    at_neg();
    chk("single_done_valid", 64'(rsp_valid), 64'd1);
    tick();
    at_neg();
    chk("single_release_valid", 64'(rsp_valid), 64'd0);
    tick();

    // Valid dropped before the edge: nothing accepted
    in_valid0 = 1'b1; in_a0 = 16'd9;
    #2;
    in_valid0 = 1'b0;
    tick();
    at_neg();
    chk("drop_mul_a", 64'(mul_a), 64'd3);
    chk("drop_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("drop_ready0", 64'(in_ready0), 64'd0);
    tick();

    // Backpressure: hold DONE for 5 cycles, requester 1 waiting
    rsp_ready = 1'b0;
    in_valid0 = 1'b1; in_a0 = 16'h00FF; in_b0 = 16'h0101;
    q1.push_back('{id: 1'b0, m: MW'(34'hFFFF)});
    tick();
    in_valid0 = 1'b0;
    in_valid1 = 1'b1; in_a1 = 16'd4; in_b1 = 16'd6;
    tick();
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_m", 64'(rsp_m), 64'hFFFF);
      chk("bp_rsp_id", 64'(rsp_id), 64'd0);
      chk("bp_ready0", 64'(in_ready0), 64'd0);
      chk("bp_ready1", 64'(in_ready1), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    q1.push_back('{id: 1'b1, m: MW'(34'd24)});
    tick();
    at_neg();
    chk("bp_resume_ready1", 64'(in_ready1), 64'd1);
    tick();
    in_valid1 = 1'b0;
    tick();
    tick();

    // Reset during BUSY drops the transaction
    in_valid0 = 1'b1; in_a0 = 16'd7; in_b0 = 16'd7;
    tick();
    in_valid0 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_mul_a", 64'(mul_a), 64'd0);
    chk("rstmid_mul_b", 64'(mul_b), 64'd0);
    chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("rstmid_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    in_valid0 = 1'b1; in_a0 = 16'd5; in_b0 = 16'd6;
    in_valid1 = 1'b1; in_a1 = 16'd1; in_b1 = 16'd1;
    q1.push_back('{id: 1'b0, m: MW'(34'd30)});
    at_neg();
    chk("rstmid_tie_ready0", 64'(in_ready0), 64'd1);
    chk("rstmid_tie_ready1", 64'(in_ready1), 64'd0);
    tick();
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    tick();
    tick();

    // Settle time on the LAT=4 instance; requester inputs change while BUSY
    v4_1 = 1'b1; a4_1 = 16'd1024; b4_1 = 16'd32;
    q4.push_back('{id: 1'b1, m: MW'(34'd32768)});
    at_neg();
    chk("lat4_ready1", 64'(r4_1), 64'd1);
    tick();
    v4_1 = 1'b0; a4_1 = 16'hFFFF; b4_1 = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("lat4_mul_a", 64'(mul_a4), 64'd1024);
      chk("lat4_mul_b", 64'(mul_b4), 64'd32);
      chk("lat4_busy_valid", 64'(rsp_valid4), 64'd0);
      tick();
    end
    at_neg();
    chk("lat4_done_valid", 64'(rsp_valid4), 64'd1);
    tick();
    tick();

`ifdef ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i < 10) begin
        in_valid0 = 1'b1; in_a0 = 16'(i + 1); in_b0 = 16'd2;
        q1.push_back('{id: 1'b0, m: MW'((i + 1) * 2)});
      end else begin
        in_valid1 = 1'b1; in_a1 = 16'(i + 1); in_b1 = 16'd3;
        q1.push_back('{id: 1'b1, m: MW'((i + 1) * 3)});
      end
      at_neg();
      chk("stats_ready", 64'(in_ready0 | in_ready1), 64'd1);
      tick();
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      tick();
      tick();
    end
    chk("stats_gnt_cnt0", 64'(gnt_cnt0), 64'd10);
    chk("stats_gnt_cnt1", 64'(gnt_cnt1), 64'd3);
    rst = 1'b1;
    #1;
    chk("stats_rst_cnt0", 64'(gnt_cnt0), 64'd0);
    chk("stats_rst_cnt1", 64'(gnt_cnt1), 64'd0);
    tick();
    rst = 1'b0;
    tick();
`endif

    tick();
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q4_drained", 64'(q4.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
